// File: rtl/uart_conv_ctrl.sv
// uart_conv_ctrl: circular byte FIFO sequencer over a 512x64 / 4096x8 dual-port RAM,
// 64-bit words in through port A, bytes out through port B with valid/ready.
module uart_conv_ctrl #(
  parameter int RD_LAT = 2,
  parameter int DEPTH_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [12:0] level,
  output logic [63:0] ram_data_a,
  output logic [8:0]  ram_address_a,
  output logic        ram_wren_a,
  output logic [7:0]  ram_data_b,
  output logic [11:0] ram_address_b,
  output logic        ram_wren_b,
  input  logic [7:0]  ram_q_b
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
  state_t      state_q, state_d;
  logic [8:0]  wp_q, wp_d;
  logic [11:0] rp_q, rp_d;
  logic [12:0] level_q, level_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [63:0] data_a_q, data_a_d;
  logic        wren_a_q, wren_a_d;
  logic        accept, hs;
  assign in_ready = (level_q + (wren_a_q ? 13'd8 : 13'd0)) <= 13'(DEPTH_BYTES - 8);
  assign tx_valid = state_q == S_HOLD;
  assign tx_data = tx_data_q;
  assign level = level_q;
  assign ram_data_a = data_a_q;
  assign ram_address_a = wp_q;
  assign ram_wren_a = wren_a_q;
  assign ram_data_b = 8'd0;
  assign ram_wren_b = 1'b0;
  // rp only moves on a handshake, so the read address is stable from IDLE through HOLD
  assign ram_address_b = rp_q;
  always_comb begin
    accept = in_valid && in_ready;
    hs = tx_valid && tx_ready;
    wren_a_d = accept;
    data_a_d = accept ? in_data : data_a_q;
    wp_d = wren_a_q ? wp_q + 9'd1 : wp_q;
    rp_d = hs ? rp_q + 12'd1 : rp_q;
    level_d = level_q + (wren_a_q ? 13'd8 : 13'd0) - (hs ? 13'd1 : 13'd0);
    state_d = state_q;
    cnt_d = 2'd0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: state_d = (level_q != 13'd0) ? S_WAIT : S_IDLE;
      S_WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(RD_LAT - 1)) begin
          state_d = S_HOLD;
          tx_data_d = ram_q_b;
          cnt_d = 2'd0;
        end
      end
      S_HOLD: state_d = tx_ready ? S_IDLE : S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= S_IDLE;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      tx_data_q <= '0;
      data_a_q <= '0;
      wren_a_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      data_a_q <= data_a_d;
      wren_a_q <= wren_a_d;
    end
  end
endmodule

// File: tb/tb_uart_conv_ctrl.sv
// tb_uart_conv_ctrl: two DUTs (RD_LAT=2 and RD_LAT=1) on shared word stimulus, each with
// its own RAM model, byte scoreboard and fill-level reference.
module tb_uart_conv_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [63:0] in_data;
  logic        tx_ready [2];
  logic        in_ready [2];
  logic        tx_valid [2];
  logic [7:0]  tx_data [2];
  logic [12:0] level_o [2];
  logic [63:0] data_a [2];
  logic [8:0]  addr_a [2];
  logic        wren_a [2];
  logic [7:0]  data_b [2];
  logic [11:0] addr_b [2];
  logic        wren_b [2];
  logic [7:0]  q_b [2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input int l, input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL L%0d %s: got %0h expected %0h", l, n, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [7:0] mem [4096];
    logic [7:0] q1, q2;
    logic [7:0] exp_q [$];
    int mlevel = 0, wp = 0, rp = 0, acc_total = 0;
    bit pend = 0, live = 0, stall = 0;
    logic [63:0] pword = '0;
    logic [7:0] sdata = '0;

    always @(posedge clk) begin
      if (wren_a[g])
        for (int k = 0; k < 8; k++) mem[{addr_a[g], 3'(k)}] <= data_a[g][8*k +: 8];
      q1 <= mem[addr_b[g]];
      q2 <= q1;
    end
    assign q_b[g] = (g == 0) ? q2 : q1;

    uart_conv_ctrl #(.RD_LAT(g == 0 ? 2 : 1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[g]), .in_data(in_data),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
      .level(level_o[g]),
      .ram_data_a(data_a[g]), .ram_address_a(addr_a[g]), .ram_wren_a(wren_a[g]),
      .ram_data_b(data_b[g]), .ram_address_b(addr_b[g]), .ram_wren_b(wren_b[g]),
      .ram_q_b(q_b[g])
    );

    always @(negedge clk) begin
      if (live) begin
        chk(g, "level", level_o[g], mlevel);
        chk(g, "in_ready", in_ready[g], (mlevel + (pend ? 8 : 0)) <= 4088);
        chk(g, "wren_a", wren_a[g], pend);
        if (pend) begin
          chk(g, "addr_a", addr_a[g], wp);
          chk(g, "data_a", data_a[g], pword);
        end
        chk(g, "port_b_wr", {wren_b[g], data_b[g]}, 0);
        if (stall) chk(g, "stall_hold", {tx_valid[g], tx_data[g]}, {1'b1, sdata});
        if (mlevel == 0) chk(g, "empty_valid", tx_valid[g], 0);
        if (tx_valid[g] && tx_ready[g]) begin
          chk(g, "addr_b", addr_b[g], rp);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL L%0d extra_byte: got %0h expected none", g, tx_data[g]);
          end else chk(g, "tx_data", tx_data[g], exp_q.pop_front());
        end
      end
      if (rst || flush) begin
        exp_q.delete();
        mlevel = 0; wp = 0; rp = 0;
        pend = 0; stall = 0; live = 1;
      end else if (live) begin
        if (pend) begin
          mlevel += 8;
          wp = (wp + 1) % 512;
        end
        if (tx_valid[g] && tx_ready[g]) begin
          mlevel -= 1;
          rp = (rp + 1) % 4096;
        end
        pend = in_valid && in_ready[g];
        if (pend) begin
          pword = in_data;
          acc_total++;
          for (int k = 0; k < 8; k++) exp_q.push_back(in_data[8*k +: 8]);
        end
        stall = tx_valid[g] && !tx_ready[g];
        sdata = tx_data[g];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    for (int i = 0; i < budget; i++) begin
      if (level_o[0] == 0 && level_o[1] == 0 && !wren_a[0] && !wren_a[1]) break;
      for (int g = 0; g < 2; g++) tx_ready[g] = rnd ? ($urandom_range(3) != 0) : 1'b1;
      step();
    end
    for (int g = 0; g < 2; g++) chk(g, "drained", level_o[g], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    logic [7:0] b;
    rst = 1; flush = 0; in_valid = 0; in_data = '0;
    tx_ready[0] = 0; tx_ready[1] = 0;
    repeat (3) step();
    rst = 0;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_tx_valid", tx_valid[g], 0);
      chk(g, "rst_tx_data", tx_data[g], 0);
      chk(g, "rst_addr_a", addr_a[g], 0);
      chk(g, "rst_addr_b", addr_b[g], 0);
      chk(g, "rst_data_a", data_a[g], 0);
      chk(g, "rst_in_ready", in_ready[g], 1);
    end
    // single word, bytes 01..08 expected in order
    tx_ready[0] = 1; tx_ready[1] = 1;
    in_valid = 1; in_data = 64'h0807060504030201;
    step();
    in_valid = 0;
    drain(200, 0);
    // fill to full with the output stalled
    tx_ready[0] = 0; tx_ready[1] = 0;
    a0 = lane[0].acc_total; a1 = lane[1].acc_total;
    in_valid = 1;
    for (int i = 0; i < 700; i++) begin
      in_data = {$urandom, $urandom};
      step();
    end
    in_valid = 0;
    chk(0, "fill_words", lane[0].acc_total - a0, 512);
    chk(1, "fill_words", lane[1].acc_total - a1, 512);
    for (int g = 0; g < 2; g++) begin
      chk(g, "full_level", level_o[g], 4096);
      chk(g, "full_in_ready", in_ready[g], 0);
    end
    for (int i = 0; i < 100; i++) begin
      if (level_o[0] == 4088 && level_o[1] == 4088) break;
      for (int g = 0; g < 2; g++) tx_ready[g] = level_o[g] > 4088;
      step();
    end
    tx_ready[0] = 0; tx_ready[1] = 0;
    for (int g = 0; g < 2; g++) begin
      chk(g, "minus8_level", level_o[g], 4088);
      chk(g, "minus8_in_ready", in_ready[g], 1);
    end
    drain(20000, 0);
    // long stream with random backpressure, wraps both RAM ports
    a0 = lane[0].acc_total; a1 = lane[1].acc_total;
    b = 8'd0;
    for (int i = 0; i < 40000; i++) begin
      if (lane[0].acc_total - a0 >= 600 && lane[1].acc_total - a1 >= 600) break;
      in_valid = $urandom_range(3) != 0;
      for (int k = 0; k < 8; k++) in_data[8*k +: 8] = b + 8'(k);
      b = b + 8'd8;
      for (int g = 0; g < 2; g++) tx_ready[g] = $urandom_range(3) != 0;
      step();
    end
    in_valid = 0;
    chk(0, "stream_words", lane[0].acc_total - a0 >= 600, 1);
    chk(1, "stream_words", lane[1].acc_total - a1 >= 600, 1);
    drain(40000, 1);
    // flush during WAIT at level 20
    flush = 1;
    step();
    flush = 0;
    tx_ready[0] = 0; tx_ready[1] = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      step();
    end
    in_valid = 0;
    repeat (10) step();
    for (int i = 0; i < 100; i++) begin
      if (level_o[0] == 21 && level_o[1] == 21) break;
      for (int g = 0; g < 2; g++) tx_ready[g] = level_o[g] > 21;
      step();
    end
    tx_ready[0] = 0; tx_ready[1] = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid[0] && tx_valid[1]) break;
      step();
    end
    chk(0, "pre_flush_hold", tx_valid[0], 1);
    chk(1, "pre_flush_hold", tx_valid[1], 1);
    tx_ready[0] = 1; tx_ready[1] = 1;
    step();
    tx_ready[0] = 0; tx_ready[1] = 0;
    step();
    for (int g = 0; g < 2; g++) begin
      chk(g, "pre_flush_level", level_o[g], 20);
      chk(g, "pre_flush_valid", tx_valid[g], 0);
    end
    flush = 1;
    step();
    flush = 0;
    for (int g = 0; g < 2; g++) begin
      chk(g, "flush_level", level_o[g], 0);
      chk(g, "flush_valid", tx_valid[g], 0);
      chk(g, "flush_addr_a", addr_a[g], 0);
      chk(g, "flush_addr_b", addr_b[g], 0);
      chk(g, "flush_in_ready", in_ready[g], 1);
    end
    repeat (5) step();
    for (int g = 0; g < 2; g++) chk(g, "flush_idle", tx_valid[g], 0);
    in_valid = 1; in_data = 64'hF0E0D0C0B0A09080;
    step();
    in_valid = 0;
    drain(400, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
